ws2812_fill_arbiter: RTL

Round-robin scheduler that shares the `ws2812` frame-buffer write port (`rgb_data`/`led_num`/`write`) among `NUM_REQ` independent requesters. Each requester submits a fill command (start LED, LED count, colour). The block grants one command at a time and issues one `write` per LED at a paced rate. It sits between pattern generators and the `ws2812` instance, replacing direct drive of that port.

---
 rtl/ws2812_fill_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ws2812_fill_arbiter.sv
// ws2812_fill_arbiter
//   Round-robin scheduler that shares the ws2812 frame-buffer write port
//   among NUM_REQ requesters. A granted fill command (start LED, LED count,
//   colour) is expanded into one paced write strobe per LED, wrapping the
//   LED index at the end of the chain.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   req_valid  per-requester command valid
//   req_ready  per-requester accept (combinational, one-hot on the winner)
//   req_start  first LED index, LED_W bits per requester
//   req_count  LED count, LED_W bits per requester
//   req_rgb    fill colour (GRB), 24 bits per requester
//   req_done   one-cycle pulse when requester i's command completes
//   rgb_data   colour to ws2812.rgb_data
//   led_num    LED index to ws2812.led_num
//   write      one-cycle strobe per LED to ws2812.write
//   busy       high while a command is held
//   grant_id   index of the current or last granted requester
module ws2812_fill_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int NUM_LEDS  = 144,
   parameter int LED_W     = 8,
   parameter int WRITE_GAP = 0,
   localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*LED_W-1:0] req_start,
   input  logic [NUM_REQ*LED_W-1:0] req_count,
   input  logic [NUM_REQ*24-1:0]    req_rgb,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [23:0]              rgb_data,
   output logic [LED_W-1:0]         led_num,
   output logic                     write,
   output logic                     busy,
   output logic [IDW-1:0]           grant_id
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;   // a write is on the port this cycle
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;

   localparam logic [LED_W-1:0] LEDS_L = LED_W'(NUM_LEDS);
   localparam logic [LED_W-1:0] LAST_L = LED_W'(NUM_LEDS - 1);
   localparam logic [LED_W-1:0] ONE_L  = LED_W'(1);

   logic [1:0]         state;
   logic [IDW-1:0]     last;
   logic [IDW-1:0]     winner;
   logic               found;
   logic [LED_W-1:0]   idx;        // index of the next write to issue
   logic [LED_W-1:0]   remaining;  // writes still to issue after the one on the port
   logic [GW-1:0]      gap_cnt;
   logic [LED_W-1:0]   sel_start;
   logic [LED_W-1:0]   sel_count;
   logic [LED_W-1:0]   norm_count;
   logic [23:0]        sel_rgb;
   logic               sel_empty;
   logic               handshake;
   logic               issue;
   logic [NUM_REQ-1:0] grant_mask;

   // Wrap by explicit compare so a chain shorter than 2^LED_W works.
   function automatic logic [LED_W-1:0] next_index(input logic [LED_W-1:0] i);
      return (i == LAST_L) ? '0 : i + 1'b1;
   endfunction

   // Round-robin search starting just after the last granted requester.
   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[(int'(last) + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = IDW'((int'(last) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (reset && (state == S_IDLE) && found) req_ready[winner] = 1'b1;
   end

   always_comb begin
      grant_mask           = '0;
      grant_mask[grant_id] = 1'b1;
   end

   assign handshake  = |req_ready;
   assign sel_start  = req_start[int'(winner)*LED_W +: LED_W];
   assign sel_count  = req_count[int'(winner)*LED_W +: LED_W];
   assign sel_rgb    = req_rgb[int'(winner)*24 +: 24];
   assign sel_empty  = (sel_count == '0) || (sel_start >= LEDS_L);
   assign norm_count = (sel_count > LEDS_L) ? LEDS_L : sel_count;

   // Put the next write on the port: back-to-back from FILL when there is no
   // gap, or at the end of a gap.
   assign issue = ((state == S_FILL) && (remaining != '0) && (WRITE_GAP == 0)) ||
                  ((state == S_GAP) && (gap_cnt == '0));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and later statements may override
   // the defaults at the top without ordering hazards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         last      <= IDW'(NUM_REQ - 1);
         idx       <= '0;
         remaining <= '0;
         gap_cnt   <= '0;
         write     <= 1'b0;
         led_num   <= '0;
         rgb_data  <= '0;
         req_done  <= '0;
         busy      <= 1'b0;
         grant_id  <= '0;
      end else begin
         write    <= 1'b0;
         req_done <= '0;

         case (state)
            S_IDLE: begin
               if (handshake) begin
                  grant_id <= winner;
                  last     <= winner;
                  if (sel_empty) begin
                     req_done <= req_ready;
                  end else begin
                     write     <= 1'b1;
                     led_num   <= sel_start;
                     rgb_data  <= sel_rgb;
                     idx       <= next_index(sel_start);
                     remaining <= norm_count - 1'b1;
                     busy      <= 1'b1;
                     state     <= S_FILL;
                     if (norm_count == ONE_L) req_done <= req_ready;
                  end
               end
            end
            S_FILL: begin
               if (remaining == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (WRITE_GAP > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= GW'(WRITE_GAP - 1);
               end
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
               else               state   <= S_FILL;
            end
            default: state <= S_IDLE;
         endcase

         if (issue) begin
            write     <= 1'b1;
            led_num   <= idx;
            idx       <= next_index(idx);
            remaining <= remaining - 1'b1;
            if (remaining == ONE_L) req_done <= grant_mask;
         end
      end
   end

endmodule
